// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: glyph table,
// blank pattern and the per-step shift applied by the scan-rate select.
package seg_pkg;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F (index = nibble).
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] BLANK_SEG = 7'h7F;

  // Each rate step multiplies the prescaler period by 1 << RATE_SHIFT.
  localparam int RATE_SHIFT = 2;

endpackage

// File: rtl/seg_scan_display_if.sv
// Bundle of source/control inputs and display outputs of the scanner.
// master drives sources and controls; slave is the scanner itself.
interface seg_scan_display_if #(
  parameter int DIGITS   = 8,
  parameter int CHANNELS = 8
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*4*DIGITS-1:0] data_in;
  logic [SEL_W-1:0]             sel;
  logic [1:0]                   rate;
  logic                         blank_lz;
  logic [DIGITS-1:0]            dp_mask;
  logic [7:0]                   SEG;
  logic [DIGITS-1:0]            AN;
  logic                         frame_tick;

  modport master (
    output data_in, sel, rate, blank_lz, dp_mask,
    input  SEG, AN, frame_tick
  );

  modport slave (
    input  data_in, sel, rate, blank_lz, dp_mask,
    output SEG, AN, frame_tick
  );

endinterface

// File: rtl/seg_hex_decoder.sv
// Combinational nibble to active-low 7-segment glyph lookup.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed hex display driver: prescaled digit scan, frame-latched
// source shadow, leading-zero blanking and per-digit decimal points.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int CHANNELS = 8,
  parameter int SCAN_DIV = 50000,
  parameter int DIV_W    = 24
) (
  input  logic             clk,
  input  logic             clr,
  seg_scan_display_if.slave bus
);

  localparam int NW    = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SEL_W = $clog2(CHANNELS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  term;
  logic [31:0]       shamt;
  logic              step;
  logic              wrap;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_next;
  logic [NW-1:0]     shadow;
  logic [NW-1:0]     shadow_next;
  logic [NW-1:0]     chan;
  logic              reload_pend;
  logic              load;
  logic [DIGITS-1:0] blank_vec;
  logic [3:0]        nib;
  logic [6:0]        hex_seg;
  logic [6:0]        seg_lo;
  logic [7:0]        seg_q;
  logic [DIGITS-1:0] an_q;
  logic              tick_q;

  // The >= compare lets a rate drop below the running count fire at once.
  assign shamt = 32'(bus.rate) * RATE_SHIFT;
  assign term  = (DIV_W'(SCAN_DIV) << shamt) - DIV_W'(1);
  assign step  = (cnt >= term);
  assign wrap  = step && (idx == LAST_IDX);
  assign load  = reload_pend || wrap;

  // Out-of-range selects fall back to channel 0.
  always_comb begin
    chan = bus.data_in[NW-1:0];
    for (int c = 1; c < CHANNELS; c++) begin
      if (bus.sel == SEL_W'(c)) chan = bus.data_in[c*NW +: NW];
    end
  end

  always_comb begin
    idx_next = idx;
    if (wrap)      idx_next = '0;
    else if (step) idx_next = idx + IDX_W'(1);
  end

  assign shadow_next = load ? chan : shadow;

  // Digit d blanks when it and every more-significant nibble are zero.
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    blank_vec = '0;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      zero_run     = zero_run && (shadow_next[d*4 +: 4] == 4'h0);
      blank_vec[d] = bus.blank_lz && zero_run;
    end
  end

  assign nib = shadow_next[idx_next*4 +: 4];

  seg_hex_decoder u_hex (
    .nib (nib),
    .seg (hex_seg)
  );

  assign seg_lo = blank_vec[idx_next] ? BLANK_SEG : hex_seg;

  // Outputs are registered from next-state so they move with the index.
  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt         <= '0;
      idx         <= '0;
      shadow      <= '0;
      reload_pend <= 1'b1;
      tick_q      <= 1'b0;
      seg_q       <= 8'hFF;
      an_q        <= '1;
    end else begin
      cnt         <= step ? '0 : cnt + DIV_W'(1);
      idx         <= idx_next;
      shadow      <= shadow_next;
      reload_pend <= 1'b0;
      tick_q      <= wrap;
      seg_q       <= {~bus.dp_mask[idx_next], seg_lo};
      an_q        <= ~(DIGITS'(1) << idx_next);
    end
  end

  assign bus.SEG        = seg_q;
  assign bus.AN         = an_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display (4 digits, 4 channels, SCAN_DIV=4) plus
// a 3-channel instance for the out-of-range select fallback.
module tb_seg_scan_display;

  localparam int DIGITS   = 4;
  localparam int CHANNELS = 4;
  localparam int SCAN_DIV = 4;
  localparam int DIV_W    = 24;

  logic clk = 1'b0;
  logic clr;
  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  logic [12:0] exp_q[$];
  logic [7:0]  frame_seg [4] = '{8'hC0, 8'h88, 8'hA4, 8'hF9};

  seg_scan_display_if #(.DIGITS(DIGITS), .CHANNELS(CHANNELS)) bus ();
  seg_scan_display_if #(.DIGITS(DIGITS), .CHANNELS(3))        bus3 ();

  seg_scan_display #(
    .DIGITS(DIGITS), .CHANNELS(CHANNELS), .SCAN_DIV(SCAN_DIV), .DIV_W(DIV_W)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  seg_scan_display #(
    .DIGITS(DIGITS), .CHANNELS(3), .SCAN_DIV(SCAN_DIV), .DIV_W(DIV_W)
  ) dut3 (
    .clk (clk),
    .clr (clr),
    .bus (bus3)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Cycle n is the low phase following the n-th rising edge after release.
  task automatic goto(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk_main(input string tag, input logic [3:0] an, input logic [7:0] seg,
                          input logic tick);
    check_val({tag, ".an"},   32'(bus.AN),         32'(an));
    check_val({tag, ".seg"},  32'(bus.SEG),        32'(seg));
    check_val({tag, ".tick"}, 32'(bus.frame_tick), 32'(tick));
  endtask

  task automatic chk_ch3(input string tag, input logic [3:0] an, input logic [7:0] seg);
    check_val({tag, ".an"},  32'(bus3.AN),  32'(an));
    check_val({tag, ".seg"}, 32'(bus3.SEG), 32'(seg));
  endtask

  initial begin
    clr              = 1'b0;
    bus.data_in      = {16'h3333, 16'hFFFF, 16'h12A0, 16'h7777};
    bus.sel          = 2'd1;
    bus.rate         = 2'd0;
    bus.blank_lz     = 1'b0;
    bus.dp_mask      = 4'b0000;
    bus3.data_in     = {16'h2222, 16'h1111, 16'h0500};
    bus3.sel         = 2'd3;
    bus3.rate        = 2'd0;
    bus3.blank_lz    = 1'b1;
    bus3.dp_mask     = 4'b0000;

    repeat (3) @(negedge clk);
    chk_main("reset", 4'hF, 8'hFF, 1'b0);
    chk_ch3("reset3", 4'hF, 8'hFF);

    clr = 1'b1;
    @(negedge clk);
    cyc = 0;

    // Two frames of ch1 = 12A0: first digit is 3 cycles long (release edge counts).
    for (int k = 0; k < 32; k++) begin
      int d;
      d = ((k + 1) / 4) % 4;
      exp_q.push_back({(k == 15 || k == 31), ~(4'b0001 << d), frame_seg[d]});
    end
    for (int k = 0; k < 32; k++) begin
      goto(k);
      check_val("frame", {19'd0, bus.frame_tick, bus.AN, bus.SEG}, 32'(exp_q.pop_front()));
    end

    // Rate 2: 64-cycle steps; prescaler is 0 at cycle 31.
    bus.rate = 2'd2;
    goto(94);  chk_main("rate2_hold", 4'hE, 8'hC0, 1'b0);
    goto(95);  chk_main("rate2_step", 4'hD, 8'h88, 1'b0);
    goto(158); chk_main("rate2_hold2", 4'hD, 8'h88, 1'b0);
    goto(159); chk_main("rate2_step2", 4'hB, 8'hA4, 1'b0);
    goto(189); chk_main("rate_cnt30", 4'hB, 8'hA4, 1'b0);
    bus.rate = 2'd0;
    goto(190); chk_main("rate_drop", 4'h7, 8'hF9, 1'b0);
    goto(193); chk_main("rate0_hold", 4'h7, 8'hF9, 1'b0);
    goto(194); chk_main("rate0_wrap", 4'hE, 8'hC0, 1'b1);

    // Select change mid-frame must not tear the current frame.
    goto(199); chk_main("pre_sel", 4'hD, 8'h88, 1'b0);
    bus.sel = 2'd2;
    goto(203); chk_main("no_tear2", 4'hB, 8'hA4, 1'b0);
    goto(207); chk_main("no_tear3", 4'h7, 8'hF9, 1'b0);
    goto(210); chk_main("new_frame0", 4'hE, 8'h8E, 1'b1);
    goto(214); chk_main("new_frame1", 4'hD, 8'h8E, 1'b0);

    // One-cycle reset mid-frame.
    goto(219); chk_main("pre_rst", 4'hB, 8'h8E, 1'b0);
    clr = 1'b0;
    goto(220); chk_main("mid_rst", 4'hF, 8'hFF, 1'b0);
    chk_ch3("mid_rst3", 4'hF, 8'hFF);
    clr = 1'b1;
    goto(221); chk_main("post_rst", 4'hE, 8'h8E, 1'b0);
    chk_ch3("sel_oor0", 4'hE, 8'hC0);

    // Blanking and decimal points; new data lands at the wrap in cycle 236.
    bus.data_in[32 +: 16] = 16'h0050;
    bus.blank_lz          = 1'b1;
    bus.dp_mask           = 4'b0010;
    goto(225); chk_main("dp_on", 4'hD, 8'h0E, 1'b0);
    chk_ch3("sel_oor1", 4'hD, 8'hC0);
    goto(229); chk_main("hold_data", 4'hB, 8'h8E, 1'b0);
    chk_ch3("sel_oor2", 4'hB, 8'h92);
    goto(233); chk_ch3("sel_oor3", 4'h7, 8'hFF);
    goto(236); chk_main("blank_d0", 4'hE, 8'hC0, 1'b1);
    goto(241); chk_main("blank_d1", 4'hD, 8'h12, 1'b0);
    goto(245); chk_main("blank_d2", 4'hB, 8'hFF, 1'b0);
    goto(249); chk_main("blank_d3", 4'h7, 8'hFF, 1'b0);
    bus.dp_mask = 4'b1000;
    goto(250); chk_main("dp_blank", 4'h7, 8'h7F, 1'b0);
    bus.blank_lz = 1'b0;
    goto(251); chk_main("no_blank", 4'h7, 8'h40, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
